// File: rtl/spram_arb_pkg.sv
// Shared types and defaults for the image SPRAM arbiter: FSM state encoding,
// frame geometry and write-FIFO pointer sizing.
package spram_arb_pkg;

    localparam int IMG_W          = 50;
    localparam int IMG_H          = 40;
    localparam int NPIX           = IMG_W * IMG_H;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DONE  = 2'd2,
        ST_CLEAR = 2'd3
    } arb_state_e;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int FIFO_PTR_W = ptr_width(FIFO_DEPTH_DEF);

endpackage

// File: rtl/spram_arbiter_if.sv
// Client-side bundle of the SPRAM arbiter: pixel writer, display reader,
// SPRAM macro pins and frame status. slave = arbiter, master = surroundings.
interface spram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
);
    logic              i_frame_start;
    logic              i_wr_valid;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ready;
    logic              i_clear;
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_valid;
    logic              o_spram_ce;
    logic              o_spram_wre;
    logic [ADDR_W-1:0] o_spram_ad;
    logic [DATA_W-1:0] o_spram_din;
    logic [DATA_W-1:0] i_spram_dout;
    logic [ADDR_W-1:0] o_wr_cnt;
    logic              o_frame_done;
    logic              o_overflow;
    logic              o_busy;

    modport slave (
        input  i_frame_start, i_wr_valid, i_wr_data, i_clear, i_rd_req, i_rd_addr, i_spram_dout,
        output o_wr_ready, o_rd_data, o_rd_valid, o_spram_ce, o_spram_wre, o_spram_ad,
               o_spram_din, o_wr_cnt, o_frame_done, o_overflow, o_busy
    );

    modport master (
        output i_frame_start, i_wr_valid, i_wr_data, i_clear, i_rd_req, i_rd_addr, i_spram_dout,
        input  o_wr_ready, o_rd_data, o_rd_valid, o_spram_ce, o_spram_wre, o_spram_ad,
               o_spram_din, o_wr_cnt, o_frame_done, o_overflow, o_busy
    );
endinterface

// File: rtl/spram_arbiter_wr_fifo.sv
// Synchronous first-word-fall-through pixel FIFO with flush; DEPTH must be a
// power of two so the pointers wrap naturally.
module spram_wr_fifo
    import spram_arb_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = 12,
    localparam int PTR_W  = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;

    // Pixel storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; callers never push full or pop empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            case ({push, pop})
                2'b10: begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                    count_r  <= count_r + (PTR_W+1)'(1);
                end
                2'b01: begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                    count_r  <= count_r - (PTR_W+1)'(1);
                end
                2'b11: begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == (PTR_W+1)'(DEPTH));
    assign empty = (count_r == {(PTR_W+1){1'b0}});
    assign count = count_r;

endmodule

// File: rtl/spram_arbiter.sv
// Image SPRAM owner: display reads win every cycle, buffered pixel writes retire
// in free cycles. Optional clear sequence enabled by defining SPRAM_CLEAR_EN.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int                W           = 50,
    parameter int                H           = 40,
    parameter int                ADDR_W      = 15,
    parameter int                DATA_W      = 12,
    parameter int                FIFO_DEPTH  = 8,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = 12'h000
) (
    input  logic            i_clk_sys,
    input  logic            i_rst,
    spram_arbiter_if.slave  bus
);

    localparam int                CNT_W     = ptr_width(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(W * H - 1);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

    arb_state_e        state_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [ADDR_W-1:0] wr_cnt_r;
    logic              frame_done_r;
    logic              overflow_r;
    logic              rd_valid_r;
    logic [ADDR_W-1:0] ad_hold_r;
    logic [DATA_W-1:0] din_hold_r;

    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [DATA_W-1:0] fifo_dout_s;
    logic [CNT_W-1:0]  fifo_count_s;

    logic              accept_st_s;
    logic              wr_slot_s;
    logic              last_wr_s;
    logic              push_ok_s;
    logic              ovf_set_s;
    logic              flush_s;
    logic              clear_go_s;
    logic              clr_slot_s;
    logic [ADDR_W-1:0] clr_ad_s;
    logic              spram_ce_s;
    logic              spram_wre_s;
    logic [ADDR_W-1:0] spram_ad_s;
    logic [DATA_W-1:0] spram_din_s;
    logic              unused_s;

`ifdef SPRAM_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr_r;

    assign clear_go_s = bus.i_clear && (state_r != ST_CLEAR) && !bus.i_frame_start;
    assign clr_slot_s = !i_rst && !bus.i_rd_req && (state_r == ST_CLEAR) && !bus.i_frame_start;
    assign clr_ad_s   = clr_addr_r;
    assign unused_s   = ^fifo_count_s;
`else
    assign clear_go_s = 1'b0;
    assign clr_slot_s = 1'b0;
    assign clr_ad_s   = ad_hold_r;
    assign unused_s   = ^{fifo_count_s, bus.i_clear, CLEAR_COLOR};
`endif

    spram_wr_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_wr_fifo (
        .clk   (i_clk_sys),
        .rst   (i_rst),
        .flush (flush_s),
        .push  (push_ok_s),
        .pop   (wr_slot_s),
        .din   (bus.i_wr_data),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Per-cycle port grant: read first, then a FIFO pop, then a clear write.
    always_comb begin
        accept_st_s = (state_r == ST_IDLE) || (state_r == ST_FILL);
        wr_slot_s   = !i_rst && !bus.i_rd_req && (state_r == ST_FILL) && !fifo_empty_s
                      && !bus.i_frame_start && !clear_go_s;
        last_wr_s   = wr_slot_s && (wr_addr_r == LAST_ADDR);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok_s   = bus.i_wr_valid && accept_st_s && !bus.i_frame_start && !clear_go_s
                      && (!fifo_full_s || wr_slot_s);
        ovf_set_s   = bus.i_wr_valid && accept_st_s && !bus.i_frame_start && !clear_go_s
                      && fifo_full_s && !wr_slot_s;
        flush_s     = bus.i_frame_start || last_wr_s || clear_go_s;

        if (bus.i_rd_req) begin
            spram_ce_s  = 1'b1;
            spram_wre_s = 1'b0;
            spram_ad_s  = bus.i_rd_addr;
            spram_din_s = din_hold_r;
        end else if (wr_slot_s) begin
            spram_ce_s  = 1'b1;
            spram_wre_s = 1'b1;
            spram_ad_s  = wr_addr_r;
            spram_din_s = fifo_dout_s;
        end else if (clr_slot_s) begin
            spram_ce_s  = 1'b1;
            spram_wre_s = 1'b1;
            spram_ad_s  = clr_ad_s;
            spram_din_s = CLEAR_COLOR;
        end else begin
            spram_ce_s  = 1'b0;
            spram_wre_s = 1'b0;
            spram_ad_s  = ad_hold_r;
            spram_din_s = din_hold_r;
        end
    end

    // Frame FSM with write address, counters, sticky flags and read-valid tracking.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            wr_addr_r    <= {ADDR_W{1'b0}};
            wr_cnt_r     <= {ADDR_W{1'b0}};
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
            rd_valid_r   <= 1'b0;
            ad_hold_r    <= {ADDR_W{1'b0}};
            din_hold_r   <= {DATA_W{1'b0}};
`ifdef SPRAM_CLEAR_EN
            clr_addr_r   <= {ADDR_W{1'b0}};
`endif
        end else begin
            rd_valid_r   <= bus.i_rd_req;
            ad_hold_r    <= spram_ad_s;
            din_hold_r   <= spram_din_s;
            frame_done_r <= last_wr_s;
            if (bus.i_frame_start) begin
                state_r    <= ST_FILL;
                wr_addr_r  <= {ADDR_W{1'b0}};
                wr_cnt_r   <= {ADDR_W{1'b0}};
                overflow_r <= 1'b0;
            end else if (clear_go_s) begin
                state_r    <= ST_CLEAR;
`ifdef SPRAM_CLEAR_EN
                clr_addr_r <= {ADDR_W{1'b0}};
`endif
            end else begin
                if (ovf_set_s) begin
                    overflow_r <= 1'b1;
                end
                case (state_r)
                    ST_IDLE: begin
                        if (push_ok_s) begin
                            state_r <= ST_FILL;
                        end
                    end
                    ST_FILL: begin
                        // The last pixel parks the address at W*H-1 instead of wrapping.
                        if (wr_slot_s) begin
                            wr_cnt_r <= wr_cnt_r + ONE_A;
                            if (last_wr_s) begin
                                state_r <= ST_DONE;
                            end else begin
                                wr_addr_r <= wr_addr_r + ONE_A;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_DONE;
                    end
                    ST_CLEAR: begin
`ifdef SPRAM_CLEAR_EN
                        if (clr_slot_s) begin
                            if (clr_addr_r == LAST_ADDR) begin
                                state_r <= ST_IDLE;
                            end else begin
                                clr_addr_r <= clr_addr_r + ONE_A;
                            end
                        end
`else
                        state_r <= ST_IDLE;
`endif
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_wr_ready   = !fifo_full_s;
    assign bus.o_rd_valid   = rd_valid_r;
    assign bus.o_rd_data    = rd_valid_r ? bus.i_spram_dout : {DATA_W{1'b0}};
    assign bus.o_spram_ce   = spram_ce_s;
    assign bus.o_spram_wre  = spram_wre_s;
    assign bus.o_spram_ad   = spram_ad_s;
    assign bus.o_spram_din  = spram_din_s;
    assign bus.o_wr_cnt     = wr_cnt_r;
    assign bus.o_frame_done = frame_done_r;
    assign bus.o_overflow   = overflow_r;
`ifdef SPRAM_CLEAR_EN
    assign bus.o_busy       = (state_r == ST_CLEAR);
`else
    assign bus.o_busy       = 1'b0;
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a behavioural SPRAM and a write log.
module tb_spram_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 12;
    localparam int NPIX   = 2000;

    logic clk = 1'b0;
    logic rst;
    int   vec_cnt    = 0;
    int   miscmp_cnt = 0;

    always #10 clk = ~clk;

    spram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    spram_arbiter #(
        .W(50), .H(40), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .FIFO_DEPTH(8), .CLEAR_COLOR(12'h000)
    ) dut (
        .i_clk_sys (clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_rec_t;

    logic [DATA_W-1:0] spram_mem [2**ADDR_W];
    logic [DATA_W-1:0] spram_dout_r = 12'h000;
    wr_rec_t           wr_log [$];
    int                done_pulses = 0;

    assign bus.i_spram_dout = spram_dout_r;

    // SPRAM model (1-cycle read), write logger and frame_done pulse counter.
    always @(posedge clk) begin
        if (bus.o_spram_ce) begin
            if (bus.o_spram_wre) begin
                spram_mem[bus.o_spram_ad] <= bus.o_spram_din;
                wr_log.push_back({bus.o_spram_ad, bus.o_spram_din});
            end else begin
                spram_dout_r <= spram_mem[bus.o_spram_ad];
            end
        end
        if (!rst && bus.o_frame_done) begin
            done_pulses <= done_pulses + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_px(input logic [DATA_W-1:0] d, input int gap);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = d;
        cyc(1);
        bus.i_wr_valid = 1'b0;
        cyc(gap);
    endtask

    task automatic frame_start();
        bus.i_frame_start = 1'b1;
        cyc(1);
        bus.i_frame_start = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] pix(input int i);
        return DATA_W'(i) ^ 12'h5A5;
    endfunction

    initial begin
        int base;
        int dbase;
        int bad;
        logic [DATA_W-1:0] exp_d;

        rst = 1'b1;
        bus.i_frame_start = 1'b0;
        bus.i_wr_valid    = 1'b0;
        bus.i_wr_data     = 12'h000;
        bus.i_clear       = 1'b0;
        bus.i_rd_req      = 1'b0;
        bus.i_rd_addr     = 15'd0;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        check_eq("rst_wr_ready", 32'(bus.o_wr_ready), 32'd1);
        check_eq("rst_ce", 32'(bus.o_spram_ce), 32'd0);
        check_eq("rst_rd_valid", 32'(bus.o_rd_valid), 32'd0);
        check_eq("rst_wr_cnt", 32'(bus.o_wr_cnt), 32'd0);
        check_eq("rst_flags", 32'({bus.o_frame_done, bus.o_overflow, bus.o_busy}), 32'd0);

        // Full frame, one pixel every 4 cycles, no reads.
        frame_start();
        base  = wr_log.size();
        dbase = done_pulses;
        for (int i = 0; i < NPIX; i++) push_px(pix(i), 3);
        cyc(3);
        check_eq("frame_writes", 32'(wr_log.size() - base), 32'd2000);
        bad = 0;
        for (int j = 0; j < NPIX; j++) begin
            if (wr_log[base+j].a !== ADDR_W'(j) || wr_log[base+j].d !== pix(j)) bad++;
        end
        check_eq("frame_order", 32'(bad), 32'd0);
        check_eq("frame_done_pulses", 32'(done_pulses - dbase), 32'd1);
        check_eq("frame_wr_cnt", 32'(bus.o_wr_cnt), 32'd2000);
        push_px(12'hFFF, 3);
        check_eq("done_discard", 32'(wr_log.size() - base), 32'd2000);
        check_eq("done_no_ovf", 32'(bus.o_overflow), 32'd0);
        check_eq("done_ready", 32'(bus.o_wr_ready), 32'd1);

        // Write 12'hABC at address 5, then read it back.
        frame_start();
        for (int i = 0; i < 6; i++) push_px((i == 5) ? 12'hABC : pix(i), 1);
        cyc(2);
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 15'd5;
        #1;
        check_eq("rd_grant", 32'({bus.o_spram_ce, bus.o_spram_wre}), 32'd2);
        check_eq("rd_ad", 32'(bus.o_spram_ad), 32'd5);
        cyc(1);
        bus.i_rd_req = 1'b0;
        check_eq("rd_valid", 32'(bus.o_rd_valid), 32'd1);
        check_eq("rd_data", 32'(bus.o_rd_data), 32'hABC);
        cyc(1);
        check_eq("rd_valid_drop", 32'(bus.o_rd_valid), 32'd0);

        // 20 read cycles with 9 pushes: reads own the port, 9th push overflows.
        frame_start();
        base = wr_log.size();
        bad  = 0;
        for (int k = 0; k < 20; k++) begin
            bus.i_rd_req   = 1'b1;
            bus.i_rd_addr  = ADDR_W'(100 + k);
            bus.i_wr_valid = (k < 9);
            bus.i_wr_data  = DATA_W'(12'h100 + k);
            #1;
            if (bus.o_spram_ce !== 1'b1 || bus.o_spram_wre !== 1'b0 ||
                bus.o_spram_ad !== ADDR_W'(100 + k)) bad++;
            cyc(1);
        end
        check_eq("rdprio_grant", 32'(bad), 32'd0);
        check_eq("rdprio_no_writes", 32'(wr_log.size() - base), 32'd0);
        check_eq("rdprio_full", 32'(bus.o_wr_ready), 32'd0);
        check_eq("rdprio_overflow", 32'(bus.o_overflow), 32'd1);
        check_eq("rdprio_rd_valid", 32'(bus.o_rd_valid), 32'd1);
        bus.i_rd_req = 1'b0;
        push_px(12'h1FF, 12);
        check_eq("drain_writes", 32'(wr_log.size() - base), 32'd9);
        bad = 0;
        for (int j = 0; j < 9; j++) begin
            exp_d = (j < 8) ? DATA_W'(12'h100 + j) : 12'h1FF;
            if (wr_log[base+j].a !== ADDR_W'(j) || wr_log[base+j].d !== exp_d) bad++;
        end
        check_eq("drain_order", 32'(bad), 32'd0);
        check_eq("drain_wr_cnt", 32'(bus.o_wr_cnt), 32'd9);

        // Restart a frame at pixel 100 while 3 pixels sit in the FIFO.
        frame_start();
        check_eq("fs_ovf_clear", 32'(bus.o_overflow), 32'd0);
        for (int i = 0; i < 100; i++) push_px(pix(i), 3);
        cyc(2);
        check_eq("fs_wr_cnt100", 32'(bus.o_wr_cnt), 32'd100);
        base = wr_log.size();
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 15'd7;
        for (int i = 0; i < 3; i++) push_px(DATA_W'(12'h300 + i), 0);
        bus.i_frame_start = 1'b1;
        bus.i_wr_valid    = 1'b1;
        bus.i_wr_data     = 12'hEEE;
        cyc(1);
        bus.i_frame_start = 1'b0;
        bus.i_wr_valid    = 1'b0;
        bus.i_rd_req      = 1'b0;
        cyc(5);
        check_eq("fs_flushed", 32'(wr_log.size() - base), 32'd0);
        check_eq("fs_wr_cnt0", 32'(bus.o_wr_cnt), 32'd0);
        check_eq("fs_ready", 32'(bus.o_wr_ready), 32'd1);
        push_px(12'h777, 3);
        check_eq("fs_first_write", 32'(wr_log.size() - base), 32'd1);
        check_eq("fs_first_rec", 32'(wr_log[base]), 32'({15'd0, 12'h777}));
        check_eq("idle_hold", 32'({bus.o_spram_ce, bus.o_spram_ad, bus.o_spram_din}),
                 32'({1'b0, 15'd0, 12'h777}));

        // Reset with a full FIFO and sticky overflow; memory must survive.
        bus.i_rd_req = 1'b1;
        for (int k = 0; k < 9; k++) push_px(DATA_W'(12'h200 + k), 0);
        check_eq("pre_rst_ovf", 32'(bus.o_overflow), 32'd1);
        base = wr_log.size();
        bus.i_rd_req = 1'b0;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(4);
        check_eq("rst_mid_writes", 32'(wr_log.size() - base), 32'd0);
        check_eq("rst_mid_flags", 32'({bus.o_overflow, bus.o_wr_ready}), 32'd1);
        check_eq("rst_mid_cnt", 32'(bus.o_wr_cnt), 32'd0);
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 15'd0;
        cyc(1);
        bus.i_rd_req = 1'b0;
        check_eq("rst_mem_kept", 32'(bus.o_rd_data), 32'h777);

        // Clear sequence request.
        base = wr_log.size();
        bus.i_clear = 1'b1;
        cyc(1);
        bus.i_clear = 1'b0;
`ifdef SPRAM_CLEAR_EN
        check_eq("clr_busy", 32'(bus.o_busy), 32'd1);
        bad = 1;
        for (int t = 0; t < 4000; t++) begin
            if (!bus.o_busy) begin
                bad = 0;
                break;
            end
            cyc(1);
        end
        check_eq("clr_timeout", 32'(bad), 32'd0);
        check_eq("clr_writes", 32'(wr_log.size() - base), 32'd2000);
        bad = 0;
        for (int j = 0; j < NPIX; j++) begin
            if (wr_log[base+j].a !== ADDR_W'(j) || wr_log[base+j].d !== 12'h000) bad++;
        end
        check_eq("clr_order", 32'(bad), 32'd0);
`else
        cyc(50);
        check_eq("clr_ignored", 32'(wr_log.size() - base), 32'd0);
        check_eq("clr_busy0", 32'(bus.o_busy), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
